pong_round_ctrl: RTL and testbench

Round sequencer for the Pong game. It takes start-button and per-side miss indications and runs the game through idle, serve countdown, live play, point pause and game over. It owns both player scores and tells the ball logic when to re-centre, which way to serve, and when the ball may move (game active). It sits between the board-level inputs and the ball/paddle datapath, and times all pauses in video frames.

---
 rtl/pong_round_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pong_round_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_round_ctrl.sv
// Pong round sequencer: idle, serve countdown, live play, point pause and game over.
// Owns both scores and tells the ball logic when to re-centre, which way to serve and when to move.
module pong_round_ctrl #(
  parameter int c_SCORE_LIMIT  = 9,
  parameter int c_SERVE_FRAMES = 60,
  parameter int c_POINT_FRAMES = 30
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_VSync,
  input  logic       i_Game_Start,
  input  logic       i_Miss_P1,
  input  logic       i_Miss_P2,
  output logic       o_Game_Active,
  output logic       o_Ball_Reset,
  output logic       o_Serve_Dir,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [1:0] o_Winner,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [3:0] SCORE_LIMIT = 4'(c_SCORE_LIMIT);
  localparam logic [7:0] SERVE_LOAD  = 8'(c_SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LOAD  = 8'(c_POINT_FRAMES - 1);

  state_t     state_r, state_s;
  logic [7:0] timer_r, timer_s;
  logic [3:0] p1_score_r, p1_score_s, p2_score_r, p2_score_s;
  logic [3:0] p1_inc_s, p2_inc_s;
  logic [1:0] winner_r, winner_s;
  logic       serve_dir_r, serve_dir_s;
  logic       ball_reset_r, ball_reset_s;
  logic       vsync_prev_r, start_prev_r, start_armed_r;
  logic       tick_s, press_s;

  // start_armed_r stays low until the button has been seen released after reset,
  // so a button held through reset release never counts as a press.
  assign tick_s   = ~i_VSync & vsync_prev_r;
  assign press_s  = i_Game_Start & ~start_prev_r & start_armed_r;
  assign p1_inc_s = p1_score_r + 4'd1;
  assign p2_inc_s = p2_score_r + 4'd1;

  // Next-state, timer and score decisions for the round sequencer
  always_comb begin
    state_s      = state_r;
    timer_s      = timer_r;
    p1_score_s   = p1_score_r;
    p2_score_s   = p2_score_r;
    winner_s     = winner_r;
    serve_dir_s  = serve_dir_r;
    ball_reset_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_s) begin
          state_s = ST_SERVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        // ball_reset_r marks the entry cycle, whose tick is not counted
        if (tick_s && !ball_reset_r) begin
          if (timer_r == 8'd0) begin
            state_s = ST_RUNNING;
          end else begin
            timer_s = timer_r - 8'd1;
          end
        end else begin
          state_s = ST_SERVE;
        end
      end
      ST_RUNNING: begin
        if (i_Miss_P1 && i_Miss_P2) begin
          state_s = ST_SERVE;
        end else if (i_Miss_P1) begin
          p2_score_s  = p2_inc_s;
          serve_dir_s = 1'b0;
          if (p2_inc_s == SCORE_LIMIT) begin
            state_s  = ST_GAME_OVER;
            winner_s = 2'd2;
          end else begin
            state_s = ST_POINT;
          end
        end else if (i_Miss_P2) begin
          p1_score_s  = p1_inc_s;
          serve_dir_s = 1'b1;
          if (p1_inc_s == SCORE_LIMIT) begin
            state_s  = ST_GAME_OVER;
            winner_s = 2'd1;
          end else begin
            state_s = ST_POINT;
          end
        end else begin
          state_s = ST_RUNNING;
        end
      end
      ST_POINT: begin
        if (tick_s) begin
          if (timer_r == 8'd0) begin
            state_s = ST_SERVE;
          end else begin
            timer_s = timer_r - 8'd1;
          end
        end else begin
          state_s = ST_POINT;
        end
      end
      ST_GAME_OVER: begin
        if (press_s) begin
          p1_score_s  = 4'd0;
          p2_score_s  = 4'd0;
          winner_s    = 2'd0;
          serve_dir_s = 1'b0;
          state_s     = ST_SERVE;
        end else begin
          state_s = ST_GAME_OVER;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (state_s == ST_SERVE && state_r != ST_SERVE) begin
      timer_s      = SERVE_LOAD;
      ball_reset_s = 1'b1;
    end else if (state_s == ST_POINT && state_r != ST_POINT) begin
      timer_s = POINT_LOAD;
    end else begin
      ball_reset_s = 1'b0;
    end
  end

  // State, timer, score and edge-detect registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r       <= ST_IDLE;
      timer_r       <= 8'd0;
      p1_score_r    <= 4'd0;
      p2_score_r    <= 4'd0;
      winner_r      <= 2'd0;
      serve_dir_r   <= 1'b0;
      ball_reset_r  <= 1'b0;
      vsync_prev_r  <= 1'b0;
      start_prev_r  <= 1'b0;
      start_armed_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      p1_score_r    <= p1_score_s;
      p2_score_r    <= p2_score_s;
      winner_r      <= winner_s;
      serve_dir_r   <= serve_dir_s;
      ball_reset_r  <= ball_reset_s;
      vsync_prev_r  <= i_VSync;
      start_prev_r  <= i_Game_Start;
      start_armed_r <= start_armed_r | ~i_Game_Start;
    end
  end

  assign o_Game_Active = (state_r == ST_RUNNING);
  assign o_Ball_Reset  = ball_reset_r;
  assign o_Serve_Dir   = serve_dir_r;
  assign o_P1_Score    = p1_score_r;
  assign o_P2_Score    = p2_score_r;
  assign o_Winner      = winner_r;
  assign o_State       = state_r;

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Self-checking bench for pong_round_ctrl: directed round sequence plus random play,
// every cycle compared against a frame-counting game model.
module tb_pong_round_ctrl;

  localparam int LIMIT = 3;
  localparam int SERVE_N = 2;
  localparam int POINT_N = 3;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_VSync = 1'b0;
  logic       i_Game_Start = 1'b0;
  logic       i_Miss_P1 = 1'b0;
  logic       i_Miss_P2 = 1'b0;
  logic       o_Game_Active, o_Ball_Reset, o_Serve_Dir;
  logic [3:0] o_P1_Score, o_P2_Score;
  logic [1:0] o_Winner;
  logic [2:0] o_State;

  pong_round_ctrl #(
    .c_SCORE_LIMIT (LIMIT),
    .c_SERVE_FRAMES(SERVE_N),
    .c_POINT_FRAMES(POINT_N)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_VSync      (i_VSync),
    .i_Game_Start (i_Game_Start),
    .i_Miss_P1    (i_Miss_P1),
    .i_Miss_P2    (i_Miss_P2),
    .o_Game_Active(o_Game_Active),
    .o_Ball_Reset (o_Ball_Reset),
    .o_Serve_Dir  (o_Serve_Dir),
    .o_P1_Score   (o_P1_Score),
    .o_P2_Score   (o_P2_Score),
    .o_Winner     (o_Winner),
    .o_State      (o_State)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase name, ticks counted in the current pause, scores, winner, serve side
  int m_state, m_ticks, m_p1, m_p2, m_win, m_dir, m_ball;
  int m_vprev, m_sprev, m_armed;
  int vs_left = 3;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ticks = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; m_ball = 0;
    m_vprev = 0; m_sprev = 0; m_armed = 0;
  endtask

  task automatic model_step(input int vs, input int st, input int mp1, input int mp2);
    int tick, press, enter_serve;
    tick  = (m_vprev == 1 && vs == 0) ? 1 : 0;
    press = (st == 1 && m_sprev == 0 && m_armed == 1) ? 1 : 0;
    enter_serve = 0;
    if (m_state == 0) begin
      if (press == 1) enter_serve = 1;
    end else if (m_state == 1) begin
      if (tick == 1 && m_ball == 0) begin
        m_ticks++;
        if (m_ticks == SERVE_N) m_state = 2;
      end
    end else if (m_state == 2) begin
      if (mp1 == 1 && mp2 == 1) enter_serve = 1;
      else if (mp1 == 1) begin
        m_p2++; m_dir = 0;
        if (m_p2 == LIMIT) begin m_state = 4; m_win = 2; end
        else begin m_state = 3; m_ticks = 0; end
      end else if (mp2 == 1) begin
        m_p1++; m_dir = 1;
        if (m_p1 == LIMIT) begin m_state = 4; m_win = 1; end
        else begin m_state = 3; m_ticks = 0; end
      end
    end else if (m_state == 3) begin
      if (tick == 1) begin
        m_ticks++;
        if (m_ticks == POINT_N) enter_serve = 1;
      end
    end else if (m_state == 4) begin
      if (press == 1) begin
        m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; enter_serve = 1;
      end
    end
    if (enter_serve == 1) begin
      m_state = 1; m_ticks = 0;
    end
    m_ball  = enter_serve;
    m_vprev = vs;
    m_sprev = st;
    if (st == 0) m_armed = 1;
  endtask

  task automatic step();
    if (!i_Rst_L) model_reset();
    else model_step(int'(i_VSync), int'(i_Game_Start), int'(i_Miss_P1), int'(i_Miss_P2));
    @(posedge i_Clk);
    #1;
    check_eq("state", int'(o_State), m_state);
    check_eq("p1_score", int'(o_P1_Score), m_p1);
    check_eq("p2_score", int'(o_P2_Score), m_p2);
    check_eq("winner", int'(o_Winner), m_win);
    check_eq("serve_dir", int'(o_Serve_Dir), m_dir);
    check_eq("ball_reset", int'(o_Ball_Reset), m_ball);
    check_eq("game_active", int'(o_Game_Active), (m_state == 2) ? 1 : 0);
    vs_left--;
    if (vs_left == 0) begin
      i_VSync = ~i_VSync;
      vs_left = int'($urandom_range(2, 4));
    end
  endtask

  task automatic run_to(input int target, input int budget);
    for (int i = 0; i < budget && m_state != target; i++) step();
    check_eq("reach_state", int'(o_State), target);
  endtask

  task automatic press_start();
    i_Game_Start = 1'b1;
    step();
    i_Game_Start = 1'b0;
    step();
  endtask

  task automatic pulse_miss(input logic a, input logic b);
    i_Miss_P1 = a;
    i_Miss_P2 = b;
    step();
    i_Miss_P1 = 1'b0;
    i_Miss_P2 = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) step();
    i_Rst_L = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Start, serve countdown, play
    press_start();
    run_to(2, 100);

    // P1 misses: point pause, serve, play
    for (int i = 0; i < int'($urandom_range(0, 5)); i++) step();
    pulse_miss(1'b1, 1'b0);
    run_to(1, 100);
    run_to(2, 100);

    // Simultaneous misses replay the serve
    pulse_miss(1'b1, 1'b1);
    run_to(2, 100);

    // P2 misses three times: P1 wins
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) step();
      pulse_miss(1'b0, 1'b1);
      if (k < 2) run_to(2, 100);
    end
    check_eq("winner_p1", int'(o_Winner), 1);
    pulse_miss(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    press_start();

    // Random play: misses and presses in every phase
    for (int i = 0; i < 1500; i++) begin
      i_Miss_P1    = ($urandom_range(0, 7) == 0);
      i_Miss_P2    = ($urandom_range(0, 7) == 0);
      i_Game_Start = ($urandom_range(0, 5) == 0);
      step();
    end
    i_Miss_P1 = 1'b0;
    i_Miss_P2 = 1'b0;

    // Start held across reset release is not a press
    i_Game_Start = 1'b1;
    i_Rst_L = 1'b0;
    for (int i = 0; i < 2; i++) step();
    i_Rst_L = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_eq("held_start_idle", int'(o_State), 0);
    i_Game_Start = 1'b0;
    step();
    i_Game_Start = 1'b1;
    step();
    check_eq("start_after_release", int'(o_State), 1);
    i_Game_Start = 1'b0;

    // Reach P1=2, P2=1 in play, then reset asynchronously
    run_to(2, 100);
    pulse_miss(1'b0, 1'b1);
    run_to(2, 100);
    pulse_miss(1'b0, 1'b1);
    run_to(2, 100);
    pulse_miss(1'b1, 1'b0);
    run_to(2, 100);
    check_eq("pre_rst_p1", int'(o_P1_Score), 2);
    check_eq("pre_rst_p2", int'(o_P2_Score), 1);
    #2;
    i_Rst_L = 1'b0;
    #1;
    check_eq("async_state", int'(o_State), 0);
    check_eq("async_p1", int'(o_P1_Score), 0);
    check_eq("async_p2", int'(o_P2_Score), 0);
    check_eq("async_active", int'(o_Game_Active), 0);
    check_eq("async_dir", int'(o_Serve_Dir), 0);
    check_eq("async_winner", int'(o_Winner), 0);
    check_eq("async_ball", int'(o_Ball_Reset), 0);
    model_reset();
    for (int i = 0; i < 2; i++) step();
    i_Rst_L = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
